mono_ro_seq: RTL and testbench
==============================

// Module: mono_ro_seq
// PURPOSE
//  Token-driven readout sequencer for the Monopix2 column readout. Watches the chip TokOut,
//  drives Freeze/Read and a per-bit shift enable for the serial data deserializer. Counts
//  hits per freeze window, applies FIFO backpressure and guards against stuck tokens.
//  Sits between the GPIO/register configuration and the chip pins, in the CLK40 domain.
// PARAMETERS
//  DATA_BITS  27  serial bits per hit word (SHIFT_EN high-cycles per word)
//  CNT_W      8   width of the timing configuration inputs
//  HIT_W      16  width of HIT_CNT
// PORTS
//  CLK            in   1      sequencer clock (CLK40)
//  nRST           in   1      synchronous reset, active low
//  EN             in   1      readout enable
//  TOKEN          in   1      chip TokOut, asynchronous, synchronised internally
//  FIFO_FULL      in   1      downstream full; stalls the start of the next word
//  CONF_FRZ_DLY   in   CNT_W  cycles from freeze to the first READ
//  CONF_RD_HI     in   CNT_W  READ high-cycles per word; 0 is treated as 1
//  CONF_HOLD      in   CNT_W  cycles FREEZE is held after the last word
//  CONF_MAX_HITS  in   HIT_W  hit limit per freeze window; 0 = unlimited
//  CLR_ERR        in   1      clears OVF_ERR
//  FREEZE         out  1      chip Freeze
//  READ           out  1      chip Read
//  SHIFT_EN       out  1      deserializer shift enable, one cycle per bit
//  WORD_VALID     out  1      1-cycle strobe on the last SHIFT_EN cycle of a word
//  HIT_CNT        out  HIT_W  words read in the current/last window
//  BUSY           out  1      state != IDLE
//  OVF_ERR        out  1      sticky: window aborted at CONF_MAX_HITS with token still high
// BEHAVIOUR
//  Reset (nRST=0 at posedge): all outputs 0, state IDLE, counters 0, synchroniser cleared.
//   Overrides any state, including mid-word.
//  tok_s = TOKEN through 2 flops. FREEZE rises 3 edges after TOKEN is sampled high.
//  All outputs are registered. Config is sampled on entry to each timed state.
//  IDLE:   if EN & tok_s -> FREEZE<=1, HIT_CNT<=0, cnt<=CONF_FRZ_DLY, go FRZ_WAIT.
//  FRZ_WAIT: if cnt==0 -> READ_ST, else cnt--. CONF_FRZ_DLY=0 means READ starts on the
//   next edge.
//  READ_ST: READ=1 for max(CONF_RD_HI,1) cycles, then SHIFT.
//  SHIFT:  SHIFT_EN=1 for exactly DATA_BITS cycles, READ=0.
//   On the last cycle: WORD_VALID=1 and HIT_CNT<=HIT_CNT+1, saturating at all-ones.
//   Then CHECK.
//  CHECK (>=1 cycle), priority order:
//   1. ~EN or ~tok_s -> HOLD.
//   2. CONF_MAX_HITS!=0 & HIT_CNT>=CONF_MAX_HITS -> OVF_ERR<=1, HOLD.
//   3. FIFO_FULL -> stay in CHECK, READ stays 0.
//   4. else -> READ_ST.
//   Every exit to HOLD loads cnt<=CONF_HOLD.
//  HOLD:   if cnt==0 -> FREEZE<=0, go IDLE, else cnt--. A new window cannot start in the
//   same cycle FREEZE falls.
//  A word in progress (READ_ST/SHIFT) always completes. EN falling mid-word takes effect in
//   CHECK.
//  FIFO_FULL is ignored during READ_ST/SHIFT. It blocks only the start of the next word.
//  OVF_ERR: set as above. CLR_ERR clears it. Set wins over a simultaneous CLR_ERR.
//  HIT_CNT holds its value in IDLE until the next window starts.
//  Per-word period = max(CONF_RD_HI,1) + DATA_BITS + 1 cycles when unstalled.
// TESTING
//  TOKEN high for 1 word, FRZ_DLY=2, RD_HI=1, HOLD=3 -> FREEZE rises 3 edges after the
//   TOKEN sample; READ high 3 cycles later; 27 SHIFT_EN; 1 WORD_VALID; HIT_CNT=1; FREEZE
//   low 4 cycles after CHECK.
//  TOKEN high for 5 words -> 5 WORD_VALID strobes 29 cycles apart; HIT_CNT=5; no gaps in
//   FREEZE.
//  FIFO_FULL asserted during word 2 SHIFT for 10 cycles -> word 2 completes; READ for
//   word 3 starts 1 cycle after FULL drops.
//  TOKEN stuck high, MAX_HITS=4 -> exactly 4 words; OVF_ERR=1; FREEZE released after HOLD;
//   CLR_ERR clears it.
//  nRST low mid-SHIFT -> next edge: all outputs 0, BUSY=0; after release and TOKEN high,
//   a normal window runs.
//  EN dropped mid-READ -> word completes, then HOLD/IDLE; TOKEN high with EN=0 -> FREEZE
//   stays 0.

Source files
------------

// File: rtl/mono_ro_seq.sv
// Token-driven Monopix2 column readout sequencer: synchronises TokOut, sequences
// FREEZE/READ/SHIFT_EN per hit word, counts hits and guards against stuck tokens.
module mono_ro_seq #(
   parameter int DATA_BITS = 27,
   parameter int CNT_W     = 8,
   parameter int HIT_W     = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             EN,
   input  logic             TOKEN,
   input  logic             FIFO_FULL,
   input  logic [CNT_W-1:0] CONF_FRZ_DLY,
   input  logic [CNT_W-1:0] CONF_RD_HI,
   input  logic [CNT_W-1:0] CONF_HOLD,
   input  logic [HIT_W-1:0] CONF_MAX_HITS,
   input  logic             CLR_ERR,
   output logic             FREEZE,
   output logic             READ,
   output logic             SHIFT_EN,
   output logic             WORD_VALID,
   output logic [HIT_W-1:0] HIT_CNT,
   output logic             BUSY,
   output logic             OVF_ERR
);

   localparam int BIT_W = $clog2(DATA_BITS + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FRZ_WAIT = 3'd1,
      READ_ST  = 3'd2,
      SHIFT    = 3'd3,
      CHECK    = 3'd4,
      HOLD     = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [HIT_W-1:0] hit_q, hit_d;
   logic             freeze_q, freeze_d;
   logic             read_q, read_d;
   logic             shift_q, shift_d;
   logic             wv_q, wv_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;
   logic             tok_p0_q, tok_p1_q;

   // Counter load for the READ phase: a zero setting still gives one READ cycle.
   function automatic logic [CNT_W-1:0] rd_load(input logic [CNT_W-1:0] c);
      return (c == '0) ? '0 : c - 1'b1;
   endfunction

   function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] h);
      return (h == '1) ? h : h + 1'b1;
   endfunction

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      hit_d     = hit_q;
      freeze_d  = freeze_q;
      read_d    = read_q;
      shift_d   = shift_q;
      wv_d      = 1'b0;
      ovf_d     = ovf_q & ~CLR_ERR;

      case (state_q)
         IDLE: begin
            if (EN && tok_p1_q) begin
               freeze_d = 1'b1;
               hit_d    = '0;
               cnt_d    = CONF_FRZ_DLY;
               state_d  = FRZ_WAIT;
            end
         end
         FRZ_WAIT: begin
            if (cnt_q == '0) begin
               read_d  = 1'b1;
               cnt_d   = rd_load(CONF_RD_HI);
               state_d = READ_ST;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         READ_ST: begin
            if (cnt_q == '0) begin
               read_d    = 1'b0;
               shift_d   = 1'b1;
               bit_cnt_d = LAST_BIT;
               state_d   = SHIFT;
               if (DATA_BITS == 1) begin
                  wv_d  = 1'b1;
                  hit_d = sat_inc(hit_q);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SHIFT: begin
            // WORD_VALID and the hit increment land together on the final bit cycle.
            if (bit_cnt_q == '0) begin
               shift_d = 1'b0;
               state_d = CHECK;
            end else begin
               bit_cnt_d = bit_cnt_q - 1'b1;
               if (bit_cnt_q == BIT_W'(1)) begin
                  wv_d  = 1'b1;
                  hit_d = sat_inc(hit_q);
               end
            end
         end
         CHECK: begin
            if (!EN || !tok_p1_q) begin
               cnt_d   = CONF_HOLD;
               state_d = HOLD;
            end else if ((CONF_MAX_HITS != '0) && (hit_q >= CONF_MAX_HITS)) begin
               ovf_d   = 1'b1;
               cnt_d   = CONF_HOLD;
               state_d = HOLD;
            end else if (!FIFO_FULL) begin
               read_d  = 1'b1;
               cnt_d   = rd_load(CONF_RD_HI);
               state_d = READ_ST;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               freeze_d = 1'b0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            freeze_d = 1'b0;
            read_d   = 1'b0;
            shift_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         hit_q     <= '0;
         freeze_q  <= 1'b0;
         read_q    <= 1'b0;
         shift_q   <= 1'b0;
         wv_q      <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
         tok_p0_q  <= 1'b0;
         tok_p1_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         hit_q     <= hit_d;
         freeze_q  <= freeze_d;
         read_q    <= read_d;
         shift_q   <= shift_d;
         wv_q      <= wv_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
         tok_p0_q  <= TOKEN;
         tok_p1_q  <= tok_p0_q;
      end
   end

   assign FREEZE     = freeze_q;
   assign READ       = read_q;
   assign SHIFT_EN   = shift_q;
   assign WORD_VALID = wv_q;
   assign HIT_CNT    = hit_q;
   assign BUSY       = busy_q;
   assign OVF_ERR    = ovf_q;

endmodule

// File: tb/tb_mono_ro_seq.sv
// Bench for mono_ro_seq: directed window scenarios with randomised timing config,
// event times predicted from the readout timing rules and compared to a monitor log.
module tb_mono_ro_seq;
   localparam int DB = 27;
   localparam int CW = 8;
   localparam int HW = 16;

   logic          clk = 1'b0;
   logic          nrst, en, token, full, clr;
   logic [CW-1:0] frz, rdh, hold;
   logic [HW-1:0] maxh;
   logic          freeze, read, shift_en, wv, busy, ovf;
   logic [HW-1:0] hit;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mono_ro_seq #(.DATA_BITS(DB), .CNT_W(CW), .HIT_W(HW)) dut (
      .CLK(clk), .nRST(nrst), .EN(en), .TOKEN(token), .FIFO_FULL(full),
      .CONF_FRZ_DLY(frz), .CONF_RD_HI(rdh), .CONF_HOLD(hold),
      .CONF_MAX_HITS(maxh), .CLR_ERR(clr),
      .FREEZE(freeze), .READ(read), .SHIFT_EN(shift_en), .WORD_VALID(wv),
      .HIT_CNT(hit), .BUSY(busy), .OVF_ERR(ovf)
   );

   // Event log: edge index at which each output event became visible.
   int   frz_r[$], frz_f[$], rd_r[$], wv_t[$];
   int   rd_n = 0, sh_n = 0;
   logic pf = 1'b0, pr = 1'b0;

   always @(negedge clk) begin
      if (freeze === 1'b1 && pf === 1'b0) frz_r.push_back(cyc);
      if (freeze === 1'b0 && pf === 1'b1) frz_f.push_back(cyc);
      if (read === 1'b1 && pr === 1'b0) rd_r.push_back(cyc);
      if (read === 1'b1) rd_n++;
      if (shift_en === 1'b1) sh_n++;
      if (wv === 1'b1) wv_t.push_back(cyc);
      pf = freeze;
      pr = read;
   end

   int b_fr, b_ff, b_rr, b_wv, b_rd, b_sh;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic goto(input int t);
      while (cyc < t) tick(1);
   endtask

   task automatic snap();
      b_fr = frz_r.size(); b_ff = frz_f.size(); b_rr = rd_r.size();
      b_wv = wv_t.size();  b_rd = rd_n;         b_sh = sh_n;
   endtask

   function automatic int rd_len();
      return (rdh == '0) ? 1 : int'(rdh);
   endfunction

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_freeze"}, freeze, 0);
      chk({tag, "_read"}, read, 0);
      chk({tag, "_shift"}, shift_en, 0);
      chk({tag, "_wv"}, wv, 0);
      chk({tag, "_hit"}, hit, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ovf"}, ovf, 0);
   endtask

   // Expected window: one FREEZE pulse, n words of rd_len READ + DB SHIFT_EN cycles,
   // word k READ starting r1 + k*period (+ex3 from word 3 onwards for a stall).
   task automatic verify(input string tag, input int f, input int r1, input int n,
                         input int ex3, input int fall);
      int rl, p, r;
      rl = rd_len();
      p  = rl + DB + 1;
      chk({tag, "_frz_rises"}, frz_r.size() - b_fr, 1);
      if (frz_r.size() > b_fr) chk({tag, "_frz_rise_t"}, frz_r[b_fr], f);
      chk({tag, "_frz_falls"}, frz_f.size() - b_ff, 1);
      if (frz_f.size() > b_ff) chk({tag, "_frz_fall_t"}, frz_f[b_ff], fall);
      chk({tag, "_words_read"}, rd_r.size() - b_rr, n);
      chk({tag, "_words_valid"}, wv_t.size() - b_wv, n);
      for (int i = 0; i < n; i++) begin
         r = r1 + i * p + ((i >= 2) ? ex3 : 0);
         if (rd_r.size() > b_rr + i) chk($sformatf("%s_read_t%0d", tag, i), rd_r[b_rr + i], r);
         if (wv_t.size() > b_wv + i) chk($sformatf("%s_wv_t%0d", tag, i), wv_t[b_wv + i], r + rl + DB - 1);
      end
      chk({tag, "_read_cycles"}, rd_n - b_rd, n * rl);
      chk({tag, "_shift_cycles"}, sh_n - b_sh, n * DB);
      chk({tag, "_hit_cnt"}, hit, n);
      chk({tag, "_busy_end"}, busy, 0);
   endtask

   task automatic window(input string tag, input int n);
      int k, f, r1, rn, fall;
      snap();
      k     = cyc;
      token = 1'b1;
      f     = k + 3;
      r1    = f + int'(frz) + 1;
      rn    = r1 + (n - 1) * (rd_len() + DB + 1);
      goto(rn + 1);
      token = 1'b0;
      fall  = rn + rd_len() + DB + int'(hold) + 2;
      goto(fall + 2);
      verify(tag, f, r1, n, 0, fall);
   endtask

   task automatic rand_cfg();
      frz  = CW'($urandom_range(0, 4));
      rdh  = CW'($urandom_range(0, 3));
      hold = CW'($urandom_range(0, 5));
   endtask

   initial begin
      int k, f, r1, r2, r3, b, cm, fall, m, p;
      nrst = 1'b0; en = 1'b0; token = 1'b0; full = 1'b0; clr = 1'b0;
      frz = 8'd2; rdh = 8'd1; hold = 8'd3; maxh = '0;
      tick(3);
      chk_outputs_zero("reset");
      nrst = 1'b1;
      en   = 1'b1;
      tick(2);

      window("one_word", 1);
      window("five_words", 5);
      repeat (4) begin
         rand_cfg();
         window("rand_multi", $urandom_range(2, 5));
      end

      // FIFO_FULL raised mid-SHIFT of word 2 and held past its CHECK.
      rand_cfg();
      snap();
      k = cyc; token = 1'b1;
      f  = k + 3;
      r1 = f + int'(frz) + 1;
      p  = rd_len() + DB + 1;
      r2 = r1 + p;
      goto(r2 + rd_len() + 5);
      full = 1'b1;
      b = cyc + $urandom_range(25, 40);
      goto(b);
      full = 1'b0;
      r3 = b + 1;
      goto(r3 + 1);
      token = 1'b0;
      fall = r3 + rd_len() + DB + int'(hold) + 2;
      goto(fall + 2);
      verify("fifo_stall", f, r1, 3, r3 - (r1 + 2 * p), fall);

      // Stuck token with a hit limit; CLR_ERR coincides with the setting edge.
      rand_cfg();
      m    = $urandom_range(2, 4);
      maxh = HW'(m);
      snap();
      k = cyc; token = 1'b1;
      f  = k + 3;
      r1 = f + int'(frz) + 1;
      cm = r1 + (m - 1) * (rd_len() + DB + 1) + rd_len() + DB;
      goto(cm);
      clr = 1'b1;
      goto(cm + 1);
      clr   = 1'b0;
      token = 1'b0;
      chk("ovf_set_beats_clr", ovf, 1);
      fall = cm + int'(hold) + 2;
      goto(fall + 2);
      verify("ovf_window", f, r1, m, 0, fall);
      chk("ovf_sticky", ovf, 1);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      chk("ovf_cleared", ovf, 0);
      maxh = '0;
      tick(2);

      // Reset asserted in the middle of SHIFT.
      frz = 8'd1; rdh = 8'd1; hold = 8'd2;
      k = cyc; token = 1'b1;
      r1 = k + 3 + int'(frz) + 1;
      goto(r1 + rd_len() + 10);
      chk("mid_shift_active", shift_en, 1);
      nrst = 1'b0;
      tick(1);
      token = 1'b0;
      chk_outputs_zero("rst_mid_shift");
      nrst = 1'b1;
      tick(3);
      window("after_reset", 1);

      // EN dropped while READ is high; the word still completes.
      rand_cfg();
      rdh = CW'($urandom_range(2, 3));
      snap();
      k = cyc; token = 1'b1;
      f  = k + 3;
      r1 = f + int'(frz) + 1;
      goto(r1);
      en = 1'b0;
      fall = r1 + rd_len() + DB + int'(hold) + 2;
      goto(fall + 2);
      verify("en_drop", f, r1, 1, 0, fall);
      tick(20);
      chk("en_low_no_new_freeze", frz_r.size() - b_fr, 1);
      chk("en_low_freeze", freeze, 0);
      chk("en_low_busy", busy, 0);
      token = 1'b0;
      en    = 1'b1;
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
